// File: rtl/mips_multi_pkg.sv
// Shared definitions for the multi-cycle MIPS control path:
// state codes, instruction fields, mux encodings and the per-state Moore control word.
package mips_multi_pkg;

  typedef enum logic [3:0] {
    S_IF0   = 4'd0,
    S_IF1   = 4'd1,
    S_ID    = 4'd2,
    S_EXR   = 4'd3,
    S_EXI   = 4'd4,
    S_MADDR = 4'd5,
    S_MRD   = 4'd6,
    S_MWR   = 4'd7,
    S_WBR   = 4'd8,
    S_WBI   = 4'd9,
    S_WBL   = 4'd10,
    S_BEQ   = 4'd11,
    S_J     = 4'd12,
    S_HALT  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       ab_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctrl;
    logic       aluout_write;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       halted;
  } ctrl_t;

  // Controls that depend only on the state (funct only picks ADD/SUB for R-type).
  function automatic ctrl_t moore_ctrl(input state_t st, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (st)
      S_IF1: begin
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.pc_src    = PC_SRC_ALU;
        c.alu_src_b = SRCB_ONE;
        c.alu_ctrl  = ALU_ADD;
      end
      S_ID: begin
        c.ab_write     = 1'b1;
        c.aluout_write = 1'b1;
        c.alu_src_b    = SRCB_IMM;
        c.alu_ctrl     = ALU_ADD;
      end
      S_EXR: begin
        c.alu_src_a    = 1'b1;
        c.alu_src_b    = SRCB_B;
        c.alu_ctrl     = (funct == FN_SUB) ? ALU_SUB : ALU_ADD;
        c.aluout_write = 1'b1;
      end
      S_EXI, S_MADDR: begin
        c.alu_src_a    = 1'b1;
        c.alu_src_b    = SRCB_IMM;
        c.alu_ctrl     = ALU_ADD;
        c.aluout_write = 1'b1;
      end
      S_MRD: c.dmem_req = 1'b1;
      S_MWR: begin
        c.dmem_req = 1'b1;
        c.dmem_we  = 1'b1;
      end
      S_WBR: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_WBI: c.reg_write = 1'b1;
      S_WBL: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_ctrl  = ALU_SUB;
        c.pc_src    = PC_SRC_ALUOUT;
      end
      S_J: begin
        c.pc_write = 1'b1;
        c.pc_src   = PC_SRC_JUMP;
      end
      S_HALT: c.halted = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_multi_control_if.sv
// Control bundle between the main FSM (master) and the multi-cycle datapath (slave).
interface mips_multi_control_if #(parameter int CNT_W = 16);
  logic             run;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             dmem_ack;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_write;
  logic             ab_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_ctrl;
  logic             aluout_write;
  logic             mdr_write;
  logic             dmem_req;
  logic             dmem_we;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             retire;
  logic [CNT_W-1:0] instr_count;
  logic             halted;
  logic [3:0]       state;

  modport master (
    input  run, opcode, funct, zero, dmem_ack,
    output pc_write, pc_src, ir_write, ab_write, alu_src_a, alu_src_b, alu_ctrl,
           aluout_write, mdr_write, dmem_req, dmem_we, reg_write, reg_dst,
           mem_to_reg, retire, instr_count, halted, state
  );

  modport slave (
    output run, opcode, funct, zero, dmem_ack,
    input  pc_write, pc_src, ir_write, ab_write, alu_src_a, alu_src_b, alu_ctrl,
           aluout_write, mdr_write, dmem_req, dmem_we, reg_write, reg_dst,
           mem_to_reg, retire, instr_count, halted, state
  );
endinterface

// File: rtl/mips_multi_control.sv
// Main control FSM of the multi-cycle MIPS: sequences fetch/decode/execute/memory/write-back,
// drives datapath enables, and counts retired instructions for the board display.
module mips_multi_control
  import mips_multi_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                reset,
  mips_multi_control_if.master bus
);

  state_t           state_reg, state_next;
  ctrl_t            ctrl_reg;
  logic [CNT_W-1:0] count_reg;
  logic             retire_now;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IF0: if (bus.run) state_next = S_IF1;
      S_IF1: state_next = S_ID;
      S_ID: begin
        case (bus.opcode)
          OP_RTYPE:     state_next = (bus.funct == FN_ADD || bus.funct == FN_SUB) ? S_EXR : S_HALT;
          OP_ADDI:      state_next = S_EXI;
          OP_LW, OP_SW: state_next = S_MADDR;
          OP_BEQ:       state_next = S_BEQ;
          OP_J:         state_next = S_J;
          default:      state_next = S_HALT;
        endcase
      end
      S_EXR:   state_next = S_WBR;
      S_EXI:   state_next = S_WBI;
      S_MADDR: state_next = (bus.opcode == OP_SW) ? S_MWR : S_MRD;
      S_MRD:   if (bus.dmem_ack) state_next = S_WBL;
      S_MWR:   if (bus.dmem_ack) state_next = S_IF0;
      S_WBR, S_WBI, S_WBL, S_BEQ, S_J: state_next = S_IF0;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_HALT;
    endcase
  end

  // A retire coinciding with reset is dropped so the counter restarts cleanly.
  assign retire_now = !reset &&
                      ((state_reg inside {S_WBR, S_WBI, S_WBL, S_BEQ, S_J}) ||
                       (state_reg == S_MWR && bus.dmem_ack));

  // Moore controls are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IF0;
      ctrl_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= moore_ctrl(state_next, bus.funct);
      if (retire_now && count_reg != '1)
        count_reg <= count_reg + 1'b1;
    end
  end

  assign bus.pc_write     = ctrl_reg.pc_write | (state_reg == S_BEQ && bus.zero);
  assign bus.pc_src       = ctrl_reg.pc_src;
  assign bus.ir_write     = ctrl_reg.ir_write;
  assign bus.ab_write     = ctrl_reg.ab_write;
  assign bus.alu_src_a    = ctrl_reg.alu_src_a;
  assign bus.alu_src_b    = ctrl_reg.alu_src_b;
  assign bus.alu_ctrl     = ctrl_reg.alu_ctrl;
  assign bus.aluout_write = ctrl_reg.aluout_write;
  assign bus.mdr_write    = (state_reg == S_MRD) && bus.dmem_ack;
  assign bus.dmem_req     = ctrl_reg.dmem_req;
  assign bus.dmem_we      = ctrl_reg.dmem_we;
  assign bus.reg_write    = ctrl_reg.reg_write;
  assign bus.reg_dst      = ctrl_reg.reg_dst;
  assign bus.mem_to_reg   = ctrl_reg.mem_to_reg;
  assign bus.retire       = retire_now;
  assign bus.instr_count  = count_reg;
  assign bus.halted       = ctrl_reg.halted;
  assign bus.state        = state_reg;

endmodule

// File: doc/mips_multi_control.md
Name: mips_multi_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath: PC, IR, A/B, ALUOut and MDR registers, register bank, instruction ROM and data RAM.
- Sequences each instruction through fetch, decode, execute, memory and write-back.
- Drives every datapath enable and mux select, and handshakes with data memory through req/ack.
- Keeps a retired-instruction counter for board display; halts on an illegal opcode.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  project clock (the divided board clock).
- reset  in  1  synchronous, active-high.
- run  in  1  when 0, FSM parks in S_IF0 before starting the next instruction.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU result == 0.
- dmem_ack  in  1  data-memory access complete.
- pc_write  out  1  load PC.
- pc_src  out  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target IR[9:0].
- ir_write  out  1  load IR from ROM q.
- ab_write  out  1  load A/B from register bank.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = constant 1, 10 = sign-extended immediate.
- alu_ctrl  out  2  00 ADD, 01 SUB; 10 and 11 reserved, never driven.
- aluout_write  out  1  load ALUOut.
- mdr_write  out  1  load MDR from RAM q.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store.
- reg_write  out  1  register-bank write enable.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- retire  out  1  one-cycle pulse per completed instruction.
- instr_count  out  CNT_W  retired-instruction count.
- halted  out  1  FSM is in S_HALT.
- state  out  4  current state code, for display.

Behaviour:
- State codes: S_IF0=0, S_IF1=1, S_ID=2, S_EXR=3, S_EXI=4, S_MADDR=5, S_MRD=6, S_MWR=7, S_WBR=8, S_WBI=9, S_WBL=10, S_BEQ=11, S_J=12, S_HALT=15. Codes 13 and 14 are unused and go to S_HALT.
- Reset: state goes to S_IF0 and instr_count to 0. Reset has priority over every transition, including mid-handshake. The cycle after reset, all outputs are 0 except state = 0.
- Outputs are decoded from state (Moore). Only these three are Mealy: pc_write in S_BEQ, mdr_write in S_MRD, retire. Any output not listed for a state is 0.
- S_IF0: ROM is addressed by PC and q is valid next cycle. Go to S_IF1 if run=1, else stay.
- S_IF1: ir_write=1, pc_write=1, pc_src=00, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, so PC becomes PC+1. Go to S_ID.
- S_ID: ab_write=1 and aluout_write=1 with alu_src_a=0, alu_src_b=10, ADD; this precomputes the branch target PC+1+imm. Decode:
  - opcode 000000 with funct 100000 or 100010 -> S_EXR.
  - 001000 (addi) -> S_EXI.
  - 100011 (lw) or 101011 (sw) -> S_MADDR.
  - 000100 (beq) -> S_BEQ.
  - 000010 (j) -> S_J.
  - Anything else, including an unsupported R-type funct -> S_HALT.
- S_EXR: alu_src_a=1, alu_src_b=00, alu_ctrl = SUB if funct=100010 else ADD, aluout_write=1. Go to S_WBR.
- S_EXI: alu_src_a=1, alu_src_b=10, ADD, aluout_write=1. Go to S_WBI.
- S_MADDR: same controls as S_EXI. Go to S_MRD for lw, S_MWR for sw.
- S_MRD: dmem_req=1, dmem_we=0, held until dmem_ack. In the ack cycle mdr_write=1, then go to S_WBL. There is no timeout; a missing ack holds the FSM.
- S_MWR: dmem_req=1, dmem_we=1, held until dmem_ack, then go to S_IF0.
- S_WBR: reg_write=1, reg_dst=1, mem_to_reg=0.
- S_WBI: reg_write=1, reg_dst=0, mem_to_reg=0.
- S_WBL: reg_write=1, reg_dst=0, mem_to_reg=1.
- S_WBR, S_WBI and S_WBL all go to S_IF0.
- S_BEQ: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_write = zero. Go to S_IF0.
- S_J: pc_write=1, pc_src=10. Go to S_IF0.
- S_HALT: halted=1, all enables 0, dmem_req=0. Stays until reset; run is ignored.
- retire: asserted in the last cycle of an instruction, i.e. the cycle in which the FSM moves to S_IF0. That is S_WBR, S_WBI, S_WBL, S_BEQ, S_J, and S_MWR with dmem_ack.
- instr_count increments on retire and saturates at all-ones (no wrap).
- Latency per instruction: R-type and addi 5 cycles; j and beq 4; sw 4+w; lw 5+w, where w = cycles from req to ack, minimum 1.
- Simultaneous events: a retire in the same cycle as reset is discarded. run=0 never interrupts an instruction already in flight.

Decomposition:
- Shared package mips_multi_pkg holds: state codes; opcode and funct constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, FN_ADD, FN_SUB); ALU_ADD/ALU_SUB; pc_src and alu_src_b encodings.
- No sub-module. The next-state block, output decode and counter live in one module.

Test Plan:
- add (opcode 0, funct 100000), run=1: state trace 0,1,2,3,8,0; reg_write=1 and reg_dst=1 in state 8; retire pulses once; instr_count=1.
- lw with dmem_ack delayed 3 cycles: dmem_req held for 3 cycles in state 6, mdr_write only in the ack cycle, then state 10 with mem_to_reg=1; 8 cycles total.
- beq with zero=1, then with zero=0: pc_write=1 and pc_src=01 in state 11 for the first, pc_write=0 for the second; both retire.
- opcode 111111 -> state 2 then 15; halted=1; run toggling does nothing; reset returns to state 0 with instr_count=0.
- reset asserted in state 7 while dmem_req=1: next cycle dmem_req=0, state=0, no retire.
- run=0 at S_IF0 for 10 cycles: state stays 0 with all outputs 0; with CNT_W=4, 17 retires leave instr_count=15.
